// File: rtl/monitor_rendimiento_pkg.sv
// Shared types and constants for the performance monitor and its divider.
package pkg_rendimiento;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } estado_t;

    localparam logic [4:0]  FIN_REG_DEF = 5'd10;
    localparam logic [31:0] FIN_VAL_DEF = 32'h1;
    localparam logic [31:0] CPI_SAT     = 32'hFFFF_FFFF;

endpackage

// File: rtl/monitor_rendimiento_divisor.sv
// Restoring unsigned divider, one quotient bit per clock, abortable.
module divisor_secuencial
    import pkg_rendimiento::*;
#(
    parameter int unsigned DIVIDEND_W = 48,
    parameter int unsigned DIVISOR_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient
);
    localparam int unsigned         CNT_BITS   = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_BITS-1:0] STEPS_LEFT = CNT_BITS'(DIVIDEND_W - 1);
    localparam logic [CNT_BITS-1:0] LAST       = CNT_BITS'(1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_busy;
    logic                  r_done;

    logic [DIVISOR_W-1:0]  w_rem_src;
    logic [DIVISOR_W-1:0]  w_div_src;
    logic [DIVIDEND_W-1:0] w_quo_src;
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_fits;
    logic [DIVISOR_W-1:0]  w_rem_nx;

    // The start edge already performs the first step on the incoming operands,
    // so a full division takes exactly DIVIDEND_W edges.
    always_comb begin
        w_rem_src = i_start ? '0 : r_rem;
        w_quo_src = i_start ? i_dividend : r_quo;
        w_div_src = i_start ? i_divisor : r_divisor;
        w_shift   = {w_rem_src, w_quo_src[DIVIDEND_W-1]};
        w_fits    = (w_shift >= {1'b0, w_div_src});
        w_rem_nx  = w_fits ? (w_shift[DIVISOR_W-1:0] - w_div_src) : w_shift[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else if (i_start) begin
                r_divisor <= i_divisor;
                r_rem     <= w_rem_nx;
                r_quo     <= {w_quo_src[DIVIDEND_W-2:0], w_fits};
                r_count   <= STEPS_LEFT;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_rem   <= w_rem_nx;
                r_quo   <= {w_quo_src[DIVIDEND_W-2:0], w_fits};
                r_count <= r_count - LAST;
                if (r_count == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/monitor_rendimiento.sv
// Performance monitor: counts cycles, retired instructions, stalls and flushes
// between program start and end, then computes CPI in fixed point.
module monitor_rendimiento
    import pkg_rendimiento::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FRAC_W       = 16,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [4:0]  FIN_REG      = FIN_REG_DEF,
    parameter logic [31:0] FIN_VAL      = FIN_VAL_DEF
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [31:0]      Instruccion_In,
    input  logic             Stall_i,
    input  logic             flush_i,
    input  logic             valid_w_i,
    input  logic             RegWriteW_i,
    input  logic [4:0]       dirRegfile_i,
    input  logic [31:0]      ResultadoW_i,
    output logic [CNT_W-1:0] ciclos_o,
    output logic [CNT_W-1:0] instrucciones_o,
    output logic [CNT_W-1:0] stalls_o,
    output logic [CNT_W-1:0] flushes_o,
    output logic [31:0]      cpi_o,
    output logic             cpi_valid_o,
    output logic             done_o,
    output logic [1:0]       estado_o
);
    localparam int unsigned         Q_W      = CNT_W + FRAC_W;
    localparam int unsigned         STREAK_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [STREAK_W-1:0] DRAIN_V  = STREAK_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    estado_t             r_estado;
    logic [CNT_W-1:0]    r_ciclos;
    logic [CNT_W-1:0]    r_instr;
    logic [CNT_W-1:0]    r_stalls;
    logic [CNT_W-1:0]    r_flushes;
    logic [STREAK_W-1:0] r_streak;
    logic [31:0]         r_cpi;
    logic                r_cpi_valid;
    logic                r_done;

    logic [CNT_W-1:0]    w_ciclos_nx;
    logic [CNT_W-1:0]    w_instr_nx;
    logic [CNT_W-1:0]    w_stalls_nx;
    logic [CNT_W-1:0]    w_flushes_nx;
    logic [STREAK_W-1:0] w_streak_nx;
    logic                w_cuenta;
    logic                w_fin;
    logic                w_div_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [Q_W-1:0]      w_quotient;
    logic [31:0]         w_cpi;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    // The IDLE cycle that sees the first nonzero fetch already counts as RUN cycle 1.
    always_comb begin
        w_cuenta     = enable_i && ((r_estado == RUN) ||
                                    ((r_estado == IDLE) && (Instruccion_In != '0)));
        w_ciclos_nx  = inc_sat(r_ciclos, 1'b1);
        w_instr_nx   = inc_sat(r_instr, valid_w_i);
        w_stalls_nx  = inc_sat(r_stalls, Stall_i);
        w_flushes_nx = inc_sat(r_flushes, flush_i);
        w_streak_nx  = (Instruccion_In != '0) ? '0 :
                       (r_streak == DRAIN_V)  ? r_streak : r_streak + STREAK_W'(1);
        w_fin        = w_cuenta && ((RegWriteW_i && (dirRegfile_i == FIN_REG) &&
                                     (ResultadoW_i == FIN_VAL)) || (w_streak_nx == DRAIN_V));
        w_div_start  = w_fin && !clear_i && (w_instr_nx != '0);
        w_cpi        = (w_quotient > Q_W'(CPI_SAT)) ? CPI_SAT : w_quotient[31:0];
    end

    divisor_secuencial #(
        .DIVIDEND_W (Q_W),
        .DIVISOR_W  (CNT_W)
    ) u_divisor (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .i_start    (w_div_start),
        .i_abort    (clear_i),
        .i_dividend ({w_ciclos_nx, {FRAC_W{1'b0}}}),
        .i_divisor  (w_instr_nx),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni || clear_i) begin
            r_estado    <= IDLE;
            r_ciclos    <= '0;
            r_instr     <= '0;
            r_stalls    <= '0;
            r_flushes   <= '0;
            r_streak    <= '0;
            r_cpi       <= '0;
            r_cpi_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_estado)
                IDLE, RUN: begin
                    if (w_cuenta) begin
                        r_ciclos  <= w_ciclos_nx;
                        r_instr   <= w_instr_nx;
                        r_stalls  <= w_stalls_nx;
                        r_flushes <= w_flushes_nx;
                        r_streak  <= w_streak_nx;
                        r_estado  <= w_fin ? DIV : RUN;
                        r_done    <= w_fin;
                    end
                end
                DIV: begin
                    // With nothing retired the divider never started.
                    if (!w_div_busy && (r_instr == '0)) begin
                        r_cpi       <= CPI_SAT;
                        r_cpi_valid <= 1'b1;
                        r_estado    <= DONE;
                    end else if (w_div_done) begin
                        r_cpi       <= w_cpi;
                        r_cpi_valid <= 1'b1;
                        r_estado    <= DONE;
                    end
                end
                default: r_estado <= DONE;
            endcase
        end
    end

    assign ciclos_o        = r_ciclos;
    assign instrucciones_o = r_instr;
    assign stalls_o        = r_stalls;
    assign flushes_o       = r_flushes;
    assign cpi_o           = r_cpi;
    assign cpi_valid_o     = r_cpi_valid;
    assign done_o          = r_done;
    assign estado_o        = r_estado;

endmodule

// File: doc/monitor_rendimiento.md
Name: monitor_rendimiento

Overview:
- Hardware performance monitor. Sits downstream of the pipeline's writeback stage and next to its hazard/flush outputs in `top`.
- Detects program start and end, and counts clock cycles, retired instructions, stall cycles and flushes.
- At program end it computes CPI in Q16.16 fixed point with a sequential divider.
- This replaces testbench-side CPI bookkeeping with synthesizable counters readable on the board.

Parameters:
- CNT_W, 32, width of every event counter.
- FRAC_W, 16, fractional bits of the CPI result (Q(32-FRAC_W).FRAC_W).
- DRAIN_CYCLES, 4, consecutive all-zero fetch words that end the program.
- FIN_REG, 10, destination register whose write marks program end (a0).
- FIN_VAL, 1, value written to FIN_REG that marks program end.

Ports:
- clk_i  in  1  core clock.
- reset_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear: zero all counters and return to IDLE.
- enable_i  in  1  counting enable; low pauses all counters without changing state.
- Instruccion_In  in  32  word currently in fetch.
- Stall_i  in  1  pipeline stall this cycle.
- flush_i  in  1  pipeline flush this cycle.
- valid_w_i  in  1  writeback stage holds a real (non-bubble) instruction.
- RegWriteW_i  in  1  writeback register-file write enable.
- dirRegfile_i  in  5  writeback destination register.
- ResultadoW_i  in  32  writeback data.
- ciclos_o  out  CNT_W  cycles counted in RUN.
- instrucciones_o  out  CNT_W  retired instructions.
- stalls_o  out  CNT_W  stall cycles.
- flushes_o  out  CNT_W  flush cycles.
- cpi_o  out  32  CPI in Q16.16.
- cpi_valid_o  out  1  cpi_o is final.
- done_o  out  1  program end detected; counters frozen.
- estado_o  out  2  FSM state: IDLE=0, RUN=1, DIV=2, DONE=3.

Behaviour:
- Reset (reset_ni low, asynchronous): all counters, cpi_o, cpi_valid_o, done_o and zero-streak counter are 0; FSM goes to IDLE.
- IDLE -> RUN on the first cycle with enable_i=1 and Instruccion_In!=0. That cycle is counted as RUN cycle 1.
- Per RUN cycle with enable_i=1:
  - ciclos +1.
  - instrucciones +1 if valid_w_i.
  - stalls +1 if Stall_i.
  - flushes +1 if flush_i.
- All counters saturate at all-ones; no wrap.
- End condition, evaluated in RUN with enable_i=1, is either of:
  - RegWriteW_i && dirRegfile_i==FIN_REG && ResultadoW_i==FIN_VAL;
  - the zero-streak counter reaches DRAIN_CYCLES.
- Zero-streak counter: increments on each enable_i=1 cycle with Instruccion_In==0; resets to 0 on any nonzero word.
- The end cycle itself is counted in all counters. The FSM then goes RUN -> DIV, done_o=1 from the next cycle, counters frozen.
- DIV computes quotient = (ciclos << FRAC_W) / instrucciones with a restoring divider, 1 quotient bit per cycle: CNT_W+FRAC_W cycles (48 at defaults).
- DIV -> DONE when the divider finishes. cpi_o and cpi_valid_o update in the same edge.
- Quotient > 32'hFFFF_FFFF saturates to 32'hFFFF_FFFF.
- instrucciones==0: the divider is skipped; DIV -> DONE after 1 cycle with cpi_o=32'hFFFF_FFFF.
- DONE holds all outputs until clear_i.
- enable_i low in RUN or DIV: RUN pauses (no counting, no end detection); DIV continues.
- clear_i (any state, including mid-DIV): next edge zeroes everything, aborts the divider, FSM -> IDLE.
- clear_i wins over a simultaneous end condition or divider completion.
- Outputs are registered; counters are visible one cycle after the counted event.

Decomposition:
- Package pkg_rendimiento holds:
  - typedef enum estado_t {IDLE, RUN, DIV, DONE};
  - default constants FIN_REG_DEF=5'd10, FIN_VAL_DEF=32'h1;
  - CPI_SAT=32'hFFFF_FFFF.
- Sub-module divisor_secuencial (parameterized width):
  - inputs: start, dividend, divisor, abort;
  - outputs: busy, done pulse, quotient;
  - it is reused by later M-extension work.

Test Plan:
- Basic CPI: enable=1, Instruccion_In=32'h00000013 from cycle 0; valid_w_i high on cycles 2..9; x10<=1 written at cycle 9 -> ciclos=10, instrucciones=8, done_o=1; 48 cycles later cpi_o=32'h0001_4000 (1.25), cpi_valid_o=1.
- Drain end: 5 nonzero words, then Instruccion_In=0 for 4 cycles, valid_w_i every cycle -> ciclos=9, instrucciones=9, cpi_o=32'h0001_0000.
- Stall/flush counting: 3 Stall_i cycles and 2 flush_i cycles within 20 RUN cycles -> stalls=3, flushes=2; a write of 2 to x10 does not end the program.
- Zero retired: no valid_w_i, drain end after 4 zero words -> instrucciones=0, cpi_o=32'hFFFF_FFFF one cycle after DIV entry.
- Clear mid-DIV: assert clear_i 10 cycles into DIV -> next edge estado_o=0, all counters 0, cpi_valid_o stays 0; assert clear_i on an end-condition cycle -> IDLE.
- Async reset mid-RUN: drop reset_ni between clock edges -> outputs 0 immediately; restart counts from 1 on first nonzero fetch after release.
